// File: rtl/rotate_addr_gen.sv
// rotate_addr_gen
//   Converts a raster-order camera pixel stream (FRAME_WIDTH x FRAME_HEIGHT)
//   into frame-buffer write addresses for one of four rotations, with an
//   optional horizontal mirror applied before rotation. Addresses are built
//   incrementally (row base + per-pixel step), so no multipliers are used.
//   Also flags frames that carry too many or too few pixels.
//
// Ports
//   cam_clk_in      camera pixel clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   mode_in         0 none, 1 90 CW, 2 180, 3 90 CCW (latched at frame_done_in)
//   mirror_in       horizontal mirror before rotation (latched at frame_done_in)
//   frame_done_in   one-cycle pulse before the first pixel of a frame
//   valid_pixel_in  pixel_in valid this cycle
//   pixel_in        pixel data
//   valid_pixel_out pixel_out / pixel_addr_out valid (1 cycle after input)
//   pixel_out       registered pixel data
//   pixel_addr_out  frame-buffer write address for pixel_out
//   overflow_out    sticky: extra pixels arrived after a full frame
//   short_frame_out one-cycle pulse: frame ended before W*H pixels
module rotate_addr_gen #(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int PIXEL_WIDTH  = 16,
    parameter int ADDR_WIDTH   = $clog2(FRAME_WIDTH * FRAME_HEIGHT)
) (
    input  logic                   cam_clk_in,
    input  logic                   rst_n_in,
    input  logic [1:0]             mode_in,
    input  logic                   mirror_in,
    input  logic                   frame_done_in,
    input  logic                   valid_pixel_in,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic                   valid_pixel_out,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic [ADDR_WIDTH-1:0]  pixel_addr_out,
    output logic                   overflow_out,
    output logic                   short_frame_out
);

    localparam int XW = $clog2(FRAME_WIDTH + 1);
    localparam int YW = $clog2(FRAME_HEIGHT + 1);

    // Address constants. Negative steps are stored in two's complement so a
    // plain modular add moves the address in either direction.
    localparam logic [ADDR_WIDTH-1:0] C_ZERO  = '0;
    localparam logic [ADDR_WIDTH-1:0] C_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] C_W     = ADDR_WIDTH'(FRAME_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] C_H     = ADDR_WIDTH'(FRAME_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] C_W_M1  = ADDR_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] C_H_M1  = ADDR_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] C_WH_M1 = ADDR_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] C_WH_MW = ADDR_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT - FRAME_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] C_W1H   = ADDR_WIDTH'((FRAME_WIDTH - 1) * FRAME_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] C_NEG_1 = C_ZERO - C_ONE;
    localparam logic [ADDR_WIDTH-1:0] C_NEG_W = C_ZERO - C_W;
    localparam logic [ADDR_WIDTH-1:0] C_NEG_H = C_ZERO - C_H;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    // Address of pixel (0,0) for the given mode/mirror.
    function automatic logic [ADDR_WIDTH-1:0] f_start(input logic [1:0] mode, input logic mir);
        logic [ADDR_WIDTH-1:0] a;
        case (mode)
            2'd0:    a = mir ? C_W_M1  : C_ZERO;
            2'd1:    a = mir ? C_WH_M1 : C_H_M1;
            2'd2:    a = mir ? C_WH_MW : C_WH_M1;
            default: a = mir ? C_ZERO  : C_W1H;
        endcase
        return a;
    endfunction

    // Address change when x advances by one within a row.
    function automatic logic [ADDR_WIDTH-1:0] f_xstep(input logic [1:0] mode, input logic mir);
        logic [ADDR_WIDTH-1:0] s;
        case (mode)
            2'd0:    s = mir ? C_NEG_1 : C_ONE;
            2'd1:    s = mir ? C_NEG_H : C_H;
            2'd2:    s = mir ? C_ONE   : C_NEG_1;
            default: s = mir ? C_H     : C_NEG_H;
        endcase
        return s;
    endfunction

    // Address change between the first pixels of consecutive rows.
    function automatic logic [ADDR_WIDTH-1:0] f_ystep(input logic [1:0] mode);
        logic [ADDR_WIDTH-1:0] s;
        case (mode)
            2'd0:    s = C_W;
            2'd1:    s = C_NEG_1;
            2'd2:    s = C_NEG_W;
            default: s = C_ONE;
        endcase
        return s;
    endfunction

    state_t                  r_state;
    state_t                  w_state_next;
    logic [XW-1:0]           r_x;
    logic [YW-1:0]           r_y;
    logic [1:0]              r_mode;
    logic                    r_mirror;
    logic [ADDR_WIDTH-1:0]   r_addr_p0;
    logic [ADDR_WIDTH-1:0]   r_row_p0;
    logic                    r_vld_p1;
    logic [PIXEL_WIDTH-1:0]  r_pixel_p1;
    logic [ADDR_WIDTH-1:0]   r_addr_p1;
    logic                    r_ovf;
    logic                    r_short;

    logic                    w_accept;
    logic                    w_ovf_set;
    logic                    w_row_end;
    logic                    w_last;
    logic                    w_cnt_nz;
    logic [ADDR_WIDTH-1:0]   w_start;
    logic [ADDR_WIDTH-1:0]   w_xstep;
    logic [ADDR_WIDTH-1:0]   w_ystep;

    assign w_row_end = (r_x == XW'(FRAME_WIDTH - 1));
    assign w_last    = w_row_end && (r_y == YW'(FRAME_HEIGHT - 1));
    // In ACTIVE the pixel count is y*W + x, so it is non-zero exactly when
    // either counter is non-zero.
    assign w_cnt_nz  = (r_x != '0) || (r_y != '0);
    assign w_start   = f_start(mode_in, mirror_in);
    assign w_xstep   = f_xstep(r_mode, r_mirror);
    assign w_ystep   = f_ystep(r_mode);

    always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // frame_done_in takes priority over any pixel in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_ovf_set    = 1'b0;
        if (frame_done_in) begin
            w_state_next = S_ACTIVE;
        end else begin
            case (r_state)
                S_ACTIVE: begin
                    if (valid_pixel_in) begin
                        w_accept = 1'b1;
                        if (w_last) begin
                            w_state_next = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    w_ovf_set = valid_pixel_in;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Stage p0: counters, latched configuration and flags
    always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_x      <= '0;
            r_y      <= '0;
            r_mode   <= 2'd0;
            r_mirror <= 1'b0;
            r_ovf    <= 1'b0;
            r_short  <= 1'b0;
        end else begin
            r_short <= frame_done_in && (r_state == S_ACTIVE) && w_cnt_nz;
            if (frame_done_in) begin
                r_x      <= '0;
                r_y      <= '0;
                r_mode   <= mode_in;
                r_mirror <= mirror_in;
                r_ovf    <= 1'b0;
            end else begin
                if (w_ovf_set) begin
                    r_ovf <= 1'b1;
                end
                if (w_accept) begin
                    if (w_row_end) begin
                        r_x <= '0;
                        r_y <= r_y + YW'(1);
                    end else begin
                        r_x <= r_x + XW'(1);
                    end
                end
            end
        end
    end

    // Stage p0: address of the next pixel and base address of the current row.
    // Both are loaded on frame_done_in before they are ever used.
    always_ff @(posedge cam_clk_in) begin
        if (frame_done_in) begin
            r_addr_p0 <= w_start;
            r_row_p0  <= w_start;
        end else if (w_accept) begin
            if (w_row_end) begin
                r_addr_p0 <= r_row_p0 + w_ystep;
                r_row_p0  <= r_row_p0 + w_ystep;
            end else begin
                r_addr_p0 <= r_addr_p0 + w_xstep;
            end
        end
    end

    // Stage p1: registered outputs, pixel and address aligned
    always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vld_p1   <= 1'b0;
            r_pixel_p1 <= '0;
            r_addr_p1  <= '0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_pixel_p1 <= pixel_in;
                r_addr_p1  <= r_addr_p0;
            end
        end
    end

    assign valid_pixel_out = r_vld_p1;
    assign pixel_out       = r_pixel_p1;
    assign pixel_addr_out  = r_addr_p1;
    assign overflow_out    = r_ovf;
    assign short_frame_out = r_short;

endmodule

// File: tb/tb_rotate_addr_gen.sv
module tb_rotate_addr_gen;

    localparam int SW = 4;
    localparam int SH = 3;
    localparam int SA = 4;
    localparam int BW = 320;
    localparam int BH = 240;
    localparam int BA = 17;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          mirror = 1'b0;
    logic          fd = 1'b0;
    logic          vin = 1'b0;
    logic [PW-1:0] pin = '0;

    logic          s_vld, s_ovf, s_short;
    logic [PW-1:0] s_pix;
    logic [SA-1:0] s_addr;
    logic          b_vld, b_ovf, b_short;
    logic [PW-1:0] b_pix;
    logic [BA-1:0] b_addr;

    always #5 clk = ~clk;

    rotate_addr_gen #(.FRAME_WIDTH(SW), .FRAME_HEIGHT(SH), .PIXEL_WIDTH(PW), .ADDR_WIDTH(SA)) u_small (
        .cam_clk_in(clk), .rst_n_in(rst_n), .mode_in(mode), .mirror_in(mirror),
        .frame_done_in(fd), .valid_pixel_in(vin), .pixel_in(pin),
        .valid_pixel_out(s_vld), .pixel_out(s_pix), .pixel_addr_out(s_addr),
        .overflow_out(s_ovf), .short_frame_out(s_short));

    rotate_addr_gen #(.FRAME_WIDTH(BW), .FRAME_HEIGHT(BH), .PIXEL_WIDTH(PW), .ADDR_WIDTH(BA)) u_big (
        .cam_clk_in(clk), .rst_n_in(rst_n), .mode_in(mode), .mirror_in(mirror),
        .frame_done_in(fd), .valid_pixel_in(vin), .pixel_in(pin),
        .valid_pixel_out(b_vld), .pixel_out(b_pix), .pixel_addr_out(b_addr),
        .overflow_out(b_ovf), .short_frame_out(b_short));

    int n_vec = 0;
    int n_bad = 0;

    // Reference model for the small instance: frame-level pixel count only.
    bit            m_started;
    int            m_cnt;
    int            m_mode;
    bit            m_mir;
    bit            e_vld, e_ovf, e_short;
    int            e_addr;
    logic [PW-1:0] e_pix;

    function automatic int ref_addr(input int md, input bit mir, input int x, input int y,
                                    input int w, input int h);
        int xm;
        xm = mir ? (w - 1 - x) : x;
        case (md)
            0:       return y * w + xm;
            1:       return xm * h + (h - 1 - y);
            2:       return w * h - 1 - (y * w + xm);
            default: return (w - 1 - xm) * h + y;
        endcase
    endfunction

    task automatic model_reset();
        m_started = 0; m_cnt = 0; m_mode = 0; m_mir = 0;
        e_vld = 0; e_addr = 0; e_pix = '0; e_ovf = 0; e_short = 0;
    endtask

    // Apply one cycle of input, advance the model, return at posedge + 1.
    task automatic step(input bit f, input bit v, input logic [PW-1:0] p);
        fd = f; vin = v; pin = p;
        e_vld = 0; e_short = 0;
        if (f) begin
            e_short   = m_started && (m_cnt != 0) && (m_cnt != SW * SH);
            m_started = 1; m_cnt = 0; m_mode = int'(mode); m_mir = mirror;
            e_ovf     = 0;
        end else if (v && m_started) begin
            if (m_cnt < SW * SH) begin
                e_vld  = 1;
                e_addr = ref_addr(m_mode, m_mir, m_cnt % SW, m_cnt / SW, SW, SH);
                e_pix  = p;
                m_cnt++;
            end else begin
                e_ovf = 1;
            end
        end
        @(posedge clk); #1;
        fd = 0; vin = 0;
    endtask

    task automatic test_reset();
        logic [22:0] got, want;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        got  = {s_vld, s_addr, s_pix, s_ovf, s_short};
        want = '0;
        n_vec++;
        if (got !== want) begin
            n_bad++; $display("FAIL reset_small got %h want %h", got, want);
        end
        n_vec++;
        if ({b_vld, b_addr, b_pix, b_ovf, b_short} !== '0) begin
            n_bad++; $display("FAIL reset_big got %h want 0", {b_vld, b_addr, b_pix, b_ovf, b_short});
        end
        rst_n = 1'b1;
        // IDLE: pixels before the first frame_done_in are ignored.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, PW'($urandom));
            n_vec++;
            if (s_vld !== 1'b0) begin
                n_bad++; $display("FAIL idle_ignore got %b want 0", s_vld);
            end
        end
    endtask

    task automatic test_modes();
        logic [22:0] got, want;
        int tbl [5][12] = '{
            '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11},
            '{2, 5, 8, 11, 1, 4, 7, 10, 0, 3, 6, 9},
            '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0},
            '{9, 6, 3, 0, 10, 7, 4, 1, 11, 8, 5, 2},
            '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8}};
        for (int md = 0; md < 4; md++) begin
            for (int mr = 0; mr < 2; mr++) begin
                int k;
                bit v;
                mode = 2'(md); mirror = mr[0];
                step(1, 0, '0);
                k = 0;
                while (k < SW * SH) begin
                    v = (k == 0) || ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 4) == 0) mode = 2'($urandom);
                    step(0, v, PW'($urandom));
                    got  = {s_vld, s_vld ? s_addr : 4'd0, s_pix, s_ovf, s_short};
                    want = {e_vld, e_vld ? 4'(e_addr) : 4'd0, e_pix, e_ovf, e_short};
                    n_vec++;
                    if (got !== want) begin
                        n_bad++; $display("FAIL mode%0d_mir%0d pix%0d got %h want %h", md, mr, k, got, want);
                    end
                    if (e_vld && (mr == 0 || md == 0)) begin
                        n_vec++;
                        if (s_addr !== 4'(tbl[mr == 0 ? md : 4][k])) begin
                            n_bad++; $display("FAIL table_m%0d_r%0d idx%0d got %0d want %0d",
                                              md, mr, k, s_addr, tbl[mr == 0 ? md : 4][k]);
                        end
                    end
                    if (v) k++;
                end
            end
        end
    endtask

    task automatic test_overflow_short();
        logic [22:0] got, want;
        int pulses;
        mode = 2'd0; mirror = 1'b0;
        step(1, 0, '0);
        for (int i = 0; i < 13; i++) begin
            step(0, 1, PW'(i + 100));
            got  = {s_vld, s_vld ? s_addr : 4'd0, s_pix, s_ovf, s_short};
            want = {e_vld, e_vld ? 4'(e_addr) : 4'd0, e_pix, e_ovf, e_short};
            n_vec++;
            if (got !== want) begin
                n_bad++; $display("FAIL ovf_frame pix%0d got %h want %h", i, got, want);
            end
        end
        n_vec++;
        if ({s_vld, s_ovf} !== 2'b01) begin
            n_bad++; $display("FAIL ovf_13th vld/ovf got %b want 01", {s_vld, s_ovf});
        end
        repeat (3) step(0, 0, '0);
        n_vec++;
        if (s_ovf !== 1'b1) begin
            n_bad++; $display("FAIL ovf_sticky got %b want 1", s_ovf);
        end
        step(1, 0, '0);
        n_vec++;
        if ({s_ovf, s_short} !== 2'b00) begin
            n_bad++; $display("FAIL full_fd ovf/short got %b want 00", {s_ovf, s_short});
        end
        for (int i = 0; i < 5; i++) step(0, 1, PW'(i));
        step(1, 0, '0);
        pulses = int'(s_short);
        n_vec++;
        if (s_short !== 1'b1) begin
            n_bad++; $display("FAIL short_pulse got %b want 1", s_short);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0);
            pulses += int'(s_short);
        end
        n_vec++;
        if (pulses !== 1) begin
            n_bad++; $display("FAIL short_count got %0d want 1", pulses);
        end
    endtask

    task automatic test_coincident();
        logic [22:0] got, want;
        mode = 2'd0; mirror = 1'b0;
        step(1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, PW'(i));
        mode = 2'd1; mirror = 1'b1;
        step(1, 1, 16'hDEAD);
        got  = {s_vld, s_ovf, s_short};
        want = {e_vld, e_ovf, e_short};
        n_vec++;
        if (got[2:0] !== want[2:0]) begin
            n_bad++; $display("FAIL coincident vld/ovf/short got %b want %b", got[2:0], want[2:0]);
        end
        step(0, 1, 16'h1234);
        n_vec++;
        if ({s_vld, s_addr, s_pix} !== {1'b1, 4'(ref_addr(1, 1, 0, 0, SW, SH)), 16'h1234}) begin
            n_bad++; $display("FAIL after_coincident got %b/%0d/%h want 1/%0d/1234",
                              s_vld, s_addr, s_pix, ref_addr(1, 1, 0, 0, SW, SH));
        end
        mode = 2'd2; mirror = 1'b0;
        step(0, 1, 16'h0002);
        n_vec++;
        if (s_addr !== 4'(e_addr) || e_addr != ref_addr(1, 1, 1, 0, SW, SH)) begin
            n_bad++; $display("FAIL midframe_mode got %0d want %0d", s_addr, ref_addr(1, 1, 1, 0, SW, SH));
        end
    endtask

    task automatic test_async_reset();
        mode = 2'd3; mirror = 1'b0;
        step(1, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 1, PW'(i + 7));
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({s_vld, s_addr, s_pix, s_ovf, s_short} !== '0) begin
            n_bad++; $display("FAIL async_rst_small got %h want 0", {s_vld, s_addr, s_pix, s_ovf, s_short});
        end
        n_vec++;
        if ({b_vld, b_addr, b_pix, b_ovf, b_short} !== '0) begin
            n_bad++; $display("FAIL async_rst_big got %h want 0", {b_vld, b_addr, b_pix, b_ovf, b_short});
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, PW'(i));
            n_vec++;
            if (s_vld !== 1'b0 || b_vld !== 1'b0) begin
                n_bad++; $display("FAIL post_rst_idle got %b%b want 00", s_vld, b_vld);
            end
        end
        mode = 2'd1; mirror = 1'b0;
        step(1, 0, '0);
        step(0, 1, 16'h00AA);
        n_vec++;
        if ({s_vld, s_addr} !== {1'b1, 4'(ref_addr(1, 0, 0, 0, SW, SH))}) begin
            n_bad++; $display("FAIL post_rst_frame got %b/%0d want 1/%0d", s_vld, s_addr, ref_addr(1, 0, 0, 0, SW, SH));
        end
    endtask

    task automatic test_legacy();
        logic [BA-1:0] want;
        mode = 2'd3; mirror = 1'b0;
        step(1, 0, '0);
        for (int i = 0; i < BW * BH; i++) begin
            step(0, 1, PW'(i));
            want = BA'((BW - 1 - (i % BW)) * BH + (i / BW));
            n_vec++;
            if (b_vld !== 1'b1 || b_addr !== want || b_pix !== PW'(i)) begin
                n_bad++; $display("FAIL legacy pix%0d got %b/%0d want 1/%0d", i, b_vld, b_addr, want);
            end
            if (i == 0 || i == 1 || i == 319 || i == 320 || i == BW * BH - 1) begin
                want = (i == 0) ? 17'd76560 : (i == 1) ? 17'd76320 : (i == 319) ? 17'd0 :
                       (i == 320) ? 17'd76561 : 17'd239;
                n_vec++;
                if (b_addr !== want) begin
                    n_bad++; $display("FAIL legacy_point pix%0d got %0d want %0d", i, b_addr, want);
                end
            end
        end
        step(0, 1, '0);
        n_vec++;
        if ({b_vld, b_ovf} !== 2'b01) begin
            n_bad++; $display("FAIL legacy_overflow got %b want 01", {b_vld, b_ovf});
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_overflow_short();
        test_coincident();
        test_async_reset();
        test_legacy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
